ps2_host_tx: RTL

- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xF4 "enable reporting", 0xFF reset) from the FPGA to a PS/2 mouse or keyboard.
- This is the outbound half of the PS/2 link; the existing keyboard controller and serial-mouse bridge only receive.
- Drives the open-drain clock/data enables that feed the PS/2 pin tri-states.
- Runs on the bus clock, beside the PS/2 receiver that shares the same pins.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_sync_edge.sv | 35 +++
 rtl/ps2_host_tx.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: state encoding, frame size,
// debug view and the microsecond-to-cycle conversion used for all time constants.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_ERROR
  } ps2_state_e;

  localparam int FRAME_BITS = 10;

  typedef struct packed {
    ps2_state_e  state;
    logic [3:0]  bit_idx;
    logic        clk_fall;
    logic        dat_fall;
  } ps2_dbg_t;

  function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned clk_in);
    longint unsigned cyc;
    cyc = (64'(us) * 64'(clk_in)) / 64'd1_000_000;
    return 32'(cyc);
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 pin plus a registered falling-edge pulse.
// Pin edge to fall pulse is 3 clocks; flops reset high to match an idle bus.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic fall
);

  logic meta_q, sync_q, prev_q, fall_q;
  logic fall_d;

  always_comb begin
    fall_d = prev_q & ~sync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
      fall_q <= fall_d;
    end
  end

  assign sync_out = sync_q;
  assign fall     = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts one
// byte out on device clock falling edges and checks the device acknowledge.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_IN           = 25000000,
  parameter int unsigned INHIBIT_US       = 100,
  parameter int unsigned FIRST_TIMEOUT_US = 15000,
  parameter int unsigned BIT_TIMEOUT_US   = 2000
) (
  input  logic       iClk,
  input  logic       iRst,
  // Request handshake: iSend is a one-cycle strobe honoured only while oBusy=0
  // (IDLE); oBusy rises the next cycle and falls with the oDone/oError pulse.
  input  logic [7:0] iData,
  input  logic       iSend,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError,
  input  logic       iPs2Clk,
  input  logic       iPs2Dat,
  output logic       oPs2Clk,
  output logic       oPs2Dat,
  output ps2_dbg_t   oDbg
);

  localparam int unsigned INHIBIT_CYC = us_to_cycles(INHIBIT_US, CLK_IN);
  localparam int unsigned FIRST_CYC   = us_to_cycles(FIRST_TIMEOUT_US, CLK_IN);
  localparam int unsigned BIT_CYC     = us_to_cycles(BIT_TIMEOUT_US, CLK_IN);
  localparam int unsigned MAX_CYC =
    (FIRST_CYC > BIT_CYC) ? ((FIRST_CYC > INHIBIT_CYC) ? FIRST_CYC : INHIBIT_CYC)
                          : ((BIT_CYC > INHIBIT_CYC) ? BIT_CYC : INHIBIT_CYC);
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] FIRST_LOAD   = CNT_W'(FIRST_CYC);
  localparam logic [CNT_W-1:0] BIT_LOAD     = CNT_W'(BIT_CYC);
  localparam logic [3:0]       IDX_LAST     = 4'(FRAME_BITS - 1);

  logic clk_sync, clk_fall, dat_sync, dat_fall;

  ps2_sync_edge u_clk_sync (
    .clk      (iClk),
    .rst      (iRst),
    .async_in (iPs2Clk),
    .sync_out (clk_sync),
    .fall     (clk_fall)
  );

  ps2_sync_edge u_dat_sync (
    .clk      (iClk),
    .rst      (iRst),
    .async_in (iPs2Dat),
    .sync_out (dat_sync),
    .fall     (dat_fall)
  );

  ps2_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [3:0]                idx_q, idx_d;
  logic [FRAME_BITS-1:0]     frame_q, frame_d;
  logic                      ps2_clk_q, ps2_clk_d;
  logic                      ps2_dat_q, ps2_dat_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    ps2_clk_d = ps2_clk_q;
    ps2_dat_d = ps2_dat_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ps2_clk_d = 1'b1;
        ps2_dat_d = 1'b1;
        if (iSend) begin
          frame_d   = {1'b1, ~^iData, iData};
          cnt_d     = INHIBIT_LOAD;
          idx_d     = '0;
          busy_d    = 1'b1;
          ps2_clk_d = 1'b0;
          state_d   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (cnt_q == '0) begin
          ps2_dat_d = 1'b0;
          state_d   = ST_REQ;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      // Start bit is already on the line; releasing the clock hands control to the device.
      ST_REQ: begin
        ps2_clk_d = 1'b1;
        cnt_d     = FIRST_LOAD;
        idx_d     = '0;
        state_d   = ST_SHIFT;
      end

      // The falling edge that drives the stop bit moves on, so the next edge is the ack.
      ST_SHIFT: begin
        if (clk_fall) begin
          ps2_dat_d = frame_q[idx_q];
          idx_d     = idx_q + 4'd1;
          cnt_d     = BIT_LOAD;
          if (idx_q == IDX_LAST) state_d = ST_ACK;
        end else if (cnt_q == '0) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_ACK: begin
        if (clk_fall) begin
          cnt_d   = BIT_LOAD;
          state_d = dat_sync ? ST_ERROR : ST_WAIT_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_sync && dat_sync) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_ERROR: begin
        ps2_clk_d = 1'b1;
        ps2_dat_d = 1'b1;
        err_d     = 1'b1;
        busy_d    = 1'b0;
        cnt_d     = '0;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_ERROR) begin
      ps2_clk_d = 1'b1;
      ps2_dat_d = 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      frame_q   <= '0;
      ps2_clk_q <= 1'b1;
      ps2_dat_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      ps2_clk_q <= ps2_clk_d;
      ps2_dat_q <= ps2_dat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign oBusy   = busy_q;
  assign oDone   = done_q;
  assign oError  = err_q;
  assign oPs2Clk = ps2_clk_q;
  assign oPs2Dat = ps2_dat_q;

  always_comb begin
    oDbg.state    = state_q;
    oDbg.bit_idx  = idx_q;
    oDbg.clk_fall = clk_fall;
    oDbg.dat_fall = dat_fall;
  end

endmodule
